usb_endpi_buffer: RTL and testbench

- CPU-side transmit buffer and handshake engine for one USB IN endpoint.
- Decodes its control and data I/O addresses from the CPU bus and holds up to MAX_PACKET bytes written as 16-bit words.
- Serves IN tokens from the SIE: DATA packet when armed, NAK otherwise, STALL when halted.
- One instance per IN endpoint (ENDPI0, ENDPI1), sitting between the CPU I/O bus and the SIE packet transmitter.

---
 rtl/usb_endp_pkg.sv | 11 +
 rtl/endp_buf.sv | 25 ++
 rtl/usb_endpi_buffer.sv | 160 ++++++++++++++++
 tb/tb_usb_endpi_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_endp_pkg.sv
// usb_endp_pkg: state encoding and CTRL register bit positions shared by IN endpoint buffers
package usb_endp_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, SEND, WAIT_HS} endp_state_t;
    localparam int CTRL_ARM     = 15;
    localparam int CTRL_CLR_TOG = 14;
    localparam int CTRL_HALT    = 13;
    localparam int CTRL_BUSY    = 15;
    localparam int CTRL_DONE    = 14;
    localparam int CTRL_TOG     = 12;
    localparam int LEN_W        = 7;
endpackage

// File: rtl/endp_buf.sv
// endp_buf: packet RAM, 16-bit word write port, little-endian byte read port
// clk: clock; we/waddr/wdata: word write; raddr: byte address (bit 0 picks the byte); rdata: byte out
module endp_buf
    import usb_endp_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW:0]   raddr,
    output logic [7:0]    rdata
);
    logic [15:0] mem [WORDS];
    logic [15:0] word;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign word  = mem[raddr[AW:1]];
    assign rdata = raddr[0] ? word[15:8] : word[7:0];
endmodule

// File: rtl/usb_endpi_buffer.sv
// usb_endpi_buffer: CPU transmit buffer and IN-token handshake engine for one USB IN endpoint
// CPU side: io_addr/io_wr/io_rd/io_wdata in, io_rdata out (registered, CTRL at CTRL_ADDR, DATA at DATA_ADDR)
// SIE side: in_token/hs_ack/hs_timeout in; tx_start/tx_pid1/tx_zlp, tx_valid/tx_ready/tx_data/tx_last, nak, stall out
// irq: packet-done interrupt, only driven when ENDPI_IRQ_EN is defined (then CTRL reads also clear done)
module usb_endpi_buffer
    import usb_endp_pkg::*;
#(
    parameter logic [15:0] CTRL_ADDR  = 16'h5000,
    parameter logic [15:0] DATA_ADDR  = 16'h5020,
    parameter int          MAX_PACKET = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] io_addr,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    input  logic        in_token,
    input  logic        hs_ack,
    input  logic        hs_timeout,
    output logic        tx_start,
    output logic        tx_pid1,
    output logic        tx_zlp,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic        nak,
    output logic        stall,
    output logic        irq
);
    localparam int WORDS = MAX_PACKET / 2;
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [AW:0] WFULL = (AW + 1)'(WORDS);
    localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_PACKET);

    endp_state_t st, st_n;
    logic tog, tog_n, done, done_n, halt, halt_n;
    logic [AW:0] wptr, wptr_n;
    logic [LEN_W-1:0] len, len_n, rptr, rptr_n, req_len;
    logic start_n, pid_n, zlp_n, nak_n, stall_n;
    logic ctrl_wr, ctrl_rd, data_wr, buf_we, last;
    logic [7:0] buf_byte;
    logic [15:0] rdata_n;
    logic unused;

    assign ctrl_wr = io_wr && io_addr == CTRL_ADDR;
    assign ctrl_rd = io_rd && io_addr == CTRL_ADDR;
    assign data_wr = io_wr && io_addr == DATA_ADDR;
    assign req_len = io_wdata[LEN_W-1:0] > LMAX ? LMAX : io_wdata[LEN_W-1:0];
    assign buf_we  = data_wr && st == IDLE && wptr != WFULL;
    assign last    = rptr == len - 1'b1;
    assign tx_valid = st == SEND;
    assign tx_last  = tx_valid && last;
    assign tx_data  = tx_valid ? buf_byte : 8'h00;
    assign rdata_n  = ctrl_rd ? {st != IDLE, done, halt, tog, 5'b0, len} : 16'h0000;
    assign unused   = ^io_wdata[12:7];

`ifdef ENDPI_IRQ_EN
    assign irq = done;
`else
    assign irq = 1'b0;
`endif

    endp_buf #(.WORDS(WORDS), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wptr[AW-1:0]),
        .wdata (io_wdata),
        .raddr (rptr[AW:0]),
        .rdata (buf_byte)
    );

    // Token and SIE events resolve against the current state first; the
    // CPU CTRL write is applied last so it overrides them where they overlap.
    always_comb begin
        st_n    = st;
        tog_n   = tog;
        done_n  = done;
        halt_n  = halt;
        wptr_n  = wptr;
        len_n   = len;
        rptr_n  = rptr;
        start_n = 1'b0;
        pid_n   = 1'b0;
        zlp_n   = 1'b0;
        nak_n   = 1'b0;
        stall_n = 1'b0;
        if (in_token && halt) begin
            stall_n = 1'b1;
        end else if (in_token && st == IDLE) begin
            nak_n = 1'b1;
        end else if (in_token && st == ARMED) begin
            start_n = 1'b1;
            pid_n   = tog;
            zlp_n   = len == '0;
            rptr_n  = '0;
            st_n    = len == '0 ? WAIT_HS : SEND;
        end
        if (st == SEND && tx_ready) begin
            rptr_n = rptr + 1'b1;
            st_n   = last ? WAIT_HS : SEND;
        end
        if (st == WAIT_HS && hs_ack) begin
            tog_n  = ~tog;
            done_n = 1'b1;
            wptr_n = '0;
            st_n   = IDLE;
        end else if (st == WAIT_HS && hs_timeout) begin
            st_n = ARMED;
        end
        if (buf_we) wptr_n = wptr + 1'b1;
`ifdef ENDPI_IRQ_EN
        if (ctrl_rd) done_n = 1'b0;
`endif
        if (ctrl_wr) begin
            done_n = 1'b0;
            halt_n = io_wdata[CTRL_HALT];
            tog_n  = io_wdata[CTRL_CLR_TOG] ? 1'b0 : tog_n;
            if (st == IDLE) begin
                len_n  = req_len;
                wptr_n = '0;
                st_n   = io_wdata[CTRL_ARM] ? ARMED : st_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            tog      <= 1'b0;
            done     <= 1'b0;
            halt     <= 1'b0;
            wptr     <= '0;
            len      <= '0;
            rptr     <= '0;
            tx_start <= 1'b0;
            tx_pid1  <= 1'b0;
            tx_zlp   <= 1'b0;
            nak      <= 1'b0;
            stall    <= 1'b0;
            io_rdata <= 16'h0000;
        end else begin
            st       <= st_n;
            tog      <= tog_n;
            done     <= done_n;
            halt     <= halt_n;
            wptr     <= wptr_n;
            len      <= len_n;
            rptr     <= rptr_n;
            tx_start <= start_n;
            tx_pid1  <= pid_n;
            tx_zlp   <= zlp_n;
            nak      <= nak_n;
            stall    <= stall_n;
            io_rdata <= rdata_n;
        end
    end
endmodule

// File: tb/tb_usb_endpi_buffer.sv
// tb_usb_endpi_buffer: directed self-checking bench for usb_endpi_buffer
module tb_usb_endpi_buffer;
    localparam logic [15:0] CTRL = 16'h5000;
    localparam logic [15:0] DATA = 16'h5020;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [15:0] io_addr = '0, io_wdata = '0, io_rdata;
    logic io_wr = 1'b0, io_rd = 1'b0;
    logic in_token = 1'b0, hs_ack = 1'b0, hs_timeout = 1'b0, tx_ready = 1'b1;
    logic tx_start, tx_pid1, tx_zlp, tx_valid, tx_last, nak, stall, irq;
    logic [7:0] tx_data;
    int tests = 0, fails = 0;

    usb_endpi_buffer #(.CTRL_ADDR(CTRL), .DATA_ADDR(DATA), .MAX_PACKET(8)) dut (
        .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .in_token(in_token), .hs_ack(hs_ack),
        .hs_timeout(hs_timeout), .tx_start(tx_start), .tx_pid1(tx_pid1), .tx_zlp(tx_zlp),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .nak(nak), .stall(stall), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        io_addr = a; io_wdata = d; io_wr = 1'b1;
        tick();
        io_wr = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        io_addr = a; io_rd = 1'b1;
        tick();
        io_rd = 1'b0;
        check(tag, io_rdata, exp);
    endtask

    task automatic token();
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
    endtask

    task automatic hs(input logic a, input logic t);
        hs_ack = a; hs_timeout = t;
        tick();
        hs_ack = 1'b0; hs_timeout = 1'b0;
    endtask

    task automatic start_chk(input string tag, input logic pid);
        check({tag, "_start"}, tx_start, 1'b1);
        check({tag, "_pid"}, tx_pid1, pid);
        check({tag, "_zlp"}, tx_zlp, 1'b0);
    endtask

    task automatic recv(input string tag, input int n, input logic [63:0] exp);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            while (!tx_valid && w < 10) begin
                tick();
                w++;
            end
            check($sformatf("%s_valid%0d", tag, i), tx_valid, 1'b1);
            check($sformatf("%s_byte%0d", tag, i), tx_data, exp[8*i +: 8]);
            check($sformatf("%s_last%0d", tag, i), tx_last, i == n - 1);
            tick();
        end
        check({tag, "_end"}, tx_valid, 1'b0);
    endtask

    task automatic idle_chk(input string tag);
        check({tag, "_start"}, tx_start, 1'b0);
        check({tag, "_valid"}, tx_valid, 1'b0);
        check({tag, "_data"}, tx_data, 8'h00);
        check({tag, "_last"}, tx_last, 1'b0);
        check({tag, "_nak"}, nak, 1'b0);
        check({tag, "_stall"}, stall, 1'b0);
        check({tag, "_irq"}, irq, 1'b0);
        check({tag, "_rdata"}, io_rdata, 16'h0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        idle_chk("rst");
        rst_n = 1'b1;
        tick();
        token();
        check("nak_pulse", nak, 1'b1);
        check("nak_nostart", tx_start, 1'b0);
        tick();
        check("nak_one", nak, 1'b0);
        rdchk("ctrl_rst", CTRL, 16'h0000);
        rdchk("data_rd", DATA, 16'h0000);

        wr(DATA, 16'h2211);
        wr(DATA, 16'h4433);
        wr(CTRL, 16'h8003);
        rdchk("ctrl_armed", CTRL, 16'h8003);
        token();
        start_chk("p1", 1'b0);
        recv("p1", 3, 64'h332211);
        hs(1'b1, 1'b0);
`ifdef ENDPI_IRQ_EN
        check("irq_set", irq, 1'b1);
        rdchk("ctrl_ack", CTRL, 16'h5003);
        check("irq_clr", irq, 1'b0);
        rdchk("ctrl_ack2", CTRL, 16'h1003);
`else
        check("irq_off", irq, 1'b0);
        rdchk("ctrl_ack", CTRL, 16'h5003);
        rdchk("ctrl_ack2", CTRL, 16'h5003);
`endif

        wr(DATA, 16'hBBAA);
        wr(DATA, 16'hDDCC);
        wr(CTRL, 16'h8004);
        token();
        start_chk("p2", 1'b1);
        check("p2_b0", tx_data, 8'hAA);
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", tx_valid, 1'b1);
            check("hold_data", tx_data, 8'hBB);
            tick();
        end
        tx_ready = 1'b1;
        recv("p2", 3, 64'hDDCCBB);
        hs(1'b1, 1'b0);

        wr(DATA, 16'h6655);
        wr(CTRL, 16'h8002);
        token();
        start_chk("p3", 1'b0);
        recv("p3", 2, 64'h6655);
        hs(1'b0, 1'b1);
        rdchk("ctrl_timeout", CTRL, 16'h8002);
        token();
        start_chk("p3r", 1'b0);
        recv("p3r", 2, 64'h6655);
        hs(1'b1, 1'b1);
        rdchk("ctrl_ackwins", CTRL, 16'h5002);

        wr(CTRL, 16'h2000);
        token();
        check("halt_stall", stall, 1'b1);
        check("halt_nostart", tx_start, 1'b0);
        check("halt_nonak", nak, 1'b0);
        rdchk("ctrl_halt", CTRL, 16'h3000);
        wr(CTRL, 16'h8000);
        token();
        check("zlp_start", tx_start, 1'b1);
        check("zlp_flag", tx_zlp, 1'b1);
        check("zlp_pid", tx_pid1, 1'b1);
        check("zlp_novalid", tx_valid, 1'b0);
        tick();
        check("zlp_novalid2", tx_valid, 1'b0);
        hs(1'b1, 1'b0);
        rdchk("ctrl_zlp", CTRL, 16'h4000);

        wr(CTRL, 16'h0000);
        wr(DATA, 16'h0201);
        wr(DATA, 16'h0403);
        wr(DATA, 16'h0605);
        wr(DATA, 16'h0807);
        wr(DATA, 16'hEEEE);
        wr(CTRL, 16'h8008);
        token();
        start_chk("p4", 1'b0);
        recv("p4", 8, 64'h0807060504030201);
        hs(1'b1, 1'b0);

        wr(CTRL, 16'h807F);
        rdchk("ctrl_clamp", CTRL, 16'h9008);
        token();
        start_chk("p5", 1'b1);
        tick();
        tick();
        check("p5_mid", tx_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        idle_chk("arst");
        #3;
        rst_n = 1'b1;
        tick();
        rdchk("ctrl_arst", CTRL, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
